// File: rtl/mips_mem_pkg.sv
// Shared state/grant encodings and width helpers for the MIPS memory-port blocks.
// Pure declarations: no logic, no latency.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_D    = 2'd2
    } gnt_t;

    // Counter only ever holds LAT-1, so LAT of 1 or 2 still needs one bit.
    function automatic int cnt_width(input int lat);
        return (lat > 2) ? $clog2(lat) : 1;
    endfunction

    // Streak must represent 0..max_streak inclusive.
    function automatic int streak_width(input int max_streak);
        return (max_streak > 1) ? $clog2(max_streak + 1) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signals of the unified memory port.
// slave = arbiter view, master = pipeline/memory environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, d_rdata, d_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_lat_counter.sv
// Loadable down-counter with zero flag for sequencing fixed-latency memory accesses.
// Load takes effect next cycle; decrement stops at zero, no backpressure.
module mem_lat_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and data with data priority and a starvation guard.
// LAT+2 cycles per access (sample, LAT access cycles, ready pulse); requesters hold req until ready.
module mem_port_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int LAT         = 1,
    parameter int MAX_DSTREAK = 4
) (
    input logic               clk,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    localparam int               CNT_W   = cnt_width(LAT);
    localparam int               STK_W   = streak_width(MAX_DSTREAK);
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(MAX_DSTREAK);
    localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(LAT - 1);

    state_t            state, state_n;
    gnt_t              gnt, gnt_n;
    logic [STK_W-1:0]  streak, streak_n;
    logic              acc_we, acc_we_n;
    logic              mem_en_q, mem_en_n;
    logic              mem_we_q, mem_we_n;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_n;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_n;
    logic              if_ready_q, if_ready_n;
    logic              d_ready_q, d_ready_n;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_n;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_n;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic              pick_d;

    mem_lat_counter #(.W(CNT_W)) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CNT_LD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // Data wins ties unless it has already taken MAX_DSTREAK grants past a waiting fetch.
    assign pick_d = bus.d_req && !(bus.if_req && (streak == STK_MAX));

    always_comb begin
        state_n     = state;
        gnt_n       = gnt;
        streak_n    = streak;
        acc_we_n    = acc_we;
        mem_en_n    = 1'b0;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        if_ready_n  = 1'b0;
        d_ready_n   = 1'b0;
        if_rdata_n  = if_rdata_q;
        d_rdata_n   = d_rdata_q;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    state_n  = ST_ACCESS;
                    cnt_load = 1'b1;
                    mem_en_n = 1'b1;
                    if (pick_d) begin
                        gnt_n       = GNT_D;
                        acc_we_n    = bus.d_we;
                        mem_we_n    = bus.d_we;
                        mem_addr_n  = bus.d_addr;
                        mem_wdata_n = bus.d_wdata;
                        if (!bus.if_req) begin
                            streak_n = '0;
                        end else if (streak != STK_MAX) begin
                            streak_n = streak + 1'b1;
                        end
                    end else begin
                        gnt_n      = GNT_IF;
                        acc_we_n   = 1'b0;
                        mem_addr_n = bus.if_addr;
                        streak_n   = '0;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    state_n = ST_DONE;
                    if (gnt == GNT_IF) begin
                        if_ready_n = 1'b1;
                        if_rdata_n = bus.mem_rdata;
                    end else begin
                        d_ready_n = 1'b1;
                        if (!acc_we) begin
                            d_rdata_n = bus.mem_rdata;
                        end
                    end
                end
            end
            // Requester still shows req during its ready cycle, so never arbitrate here.
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            gnt         <= GNT_NONE;
            streak      <= '0;
            acc_we      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state       <= state_n;
            gnt         <= gnt_n;
            streak      <= streak_n;
            acc_we      <= acc_we_n;
            mem_en_q    <= mem_en_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            if_ready_q  <= if_ready_n;
            d_ready_q   <= d_ready_n;
            if_rdata_q  <= if_rdata_n;
            d_rdata_q   <= d_rdata_n;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LAT=1 and a LAT=3 instance, each on its own small memory.
// Directed steps first, then randomized traffic checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;
    localparam int MAXD = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        noise_on;
    logic [31:0] noise;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a1 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) a3 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT1), .MAX_DSTREAK(MAXD)) dut1 (
        .clk(clk), .reset(reset), .bus(a1));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LAT(LAT3), .MAX_DSTREAK(MAXD)) dut3 (
        .clk(clk), .reset(reset), .bus(a3));

    // Combinational-read memories; read data is XORed with a per-cycle noise word so
    // the capture cycle is observable. Contents reload a known pattern on reset.
    logic [31:0] dev1 [16];
    logic [31:0] dev3 [16];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                dev1[i] <= 32'h8C08_0000 + 32'(i);
                dev3[i] <= 32'h8C08_0000 + 32'(i);
            end
        end else begin
            if (a1.mem_en && a1.mem_we) dev1[a1.mem_addr[5:2]] <= a1.mem_wdata;
            if (a3.mem_en && a3.mem_we) dev3[a3.mem_addr[5:2]] <= a3.mem_wdata;
        end
    end

    assign a1.mem_rdata = dev1[a1.mem_addr[5:2]] ^ noise;
    assign a3.mem_rdata = dev3[a3.mem_addr[5:2]] ^ noise;

    // Reference arbitration rules, phrased on the grant history only.
    function automatic logic pick_d(input logic f, input logic d, input int s);
        return d && !(f && (s == MAXD));
    endfunction

    function automatic int next_streak(input logic f, input logic d, input int s);
        if (!pick_d(f, d, s) || !f) return 0;
        return (s + 1 > MAXD) ? MAXD : s + 1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        noise = noise_on ? 32'(cyc) : 32'h0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int m_s1 = 0;

    // Holds fetch (0x4) and load (0x8) on the LAT=1 port and checks n completions.
    task automatic contend(input int n);
        int   last;
        int   t;
        logic want_d;
        a1.if_req = 1'b1; a1.if_addr = 32'h4;
        a1.d_req  = 1'b1; a1.d_we = 1'b0; a1.d_addr = 32'h8;
        last = cyc;
        for (int k = 0; k < n; k++) begin
            want_d = pick_d(1'b1, 1'b1, m_s1);
            m_s1   = next_streak(1'b1, 1'b1, m_s1);
            t = 0;
            while (!(a1.if_ready || a1.d_ready) && t < 6) begin
                step();
                t++;
            end
            chk("cont_who", {30'h0, a1.if_ready, a1.d_ready}, want_d ? 32'h1 : 32'h2);
            chk("cont_gap", 32'(cyc - last), (k == 0) ? 32'd2 : 32'd3);
            if (want_d) chk("cont_d_rdata", a1.d_rdata, 32'h8C08_0002);
            else        chk("cont_if_rdata", a1.if_rdata, 32'h8C08_0001);
            last = cyc;
            if (k == n - 1) begin
                a1.if_req = 1'b0;
                a1.d_req  = 1'b0;
            end
            step();
        end
    endtask

    // Random-phase model state
    int          m_s3, free_at, g_cyc, c, idx;
    logic        g_val, g_d, g_we, f_p, d_p, d_we_v, rdy, en_exp;
    logic [31:0] g_addr, g_wdata, f_addr_v, d_addr_v, d_wdata_v, exp_ifr, exp_dr;
    logic [31:0] ref_mem [16];
    int          r;

    initial begin
        reset = 1'b0; noise_on = 1'b0; noise = 32'h0;
        a1.if_req = 0; a1.if_addr = 0; a1.d_req = 0; a1.d_we = 0; a1.d_addr = 0; a1.d_wdata = 0;
        a3.if_req = 0; a3.if_addr = 0; a3.d_req = 0; a3.d_we = 0; a3.d_addr = 0; a3.d_wdata = 0;
        step(); step();
        chk("rst_mem_en", {31'h0, a1.mem_en}, 32'h0);
        chk("rst_if_ready", {31'h0, a1.if_ready}, 32'h0);
        chk("rst_d_ready", {31'h0, a1.d_ready}, 32'h0);
        chk("rst_d_rdata", a1.d_rdata, 32'h0);
        chk("rst_mem_addr", a1.mem_addr, 32'h0);
        chk("rst3_mem_en", {31'h0, a3.mem_en}, 32'h0);
        reset = 1'b1;
        step();

        // Fetch only, LAT=1
        a1.if_req = 1'b1; a1.if_addr = 32'h10;
        step();
        chk("fetch_mem_en", {31'h0, a1.mem_en}, 32'h1);
        chk("fetch_mem_addr", a1.mem_addr, 32'h10);
        chk("fetch_mem_we", {31'h0, a1.mem_we}, 32'h0);
        chk("fetch_early_ready", {31'h0, a1.if_ready}, 32'h0);
        step();
        chk("fetch_ready", {31'h0, a1.if_ready}, 32'h1);
        chk("fetch_rdata", a1.if_rdata, 32'h8C08_0004);
        chk("fetch_en_drop", {31'h0, a1.mem_en}, 32'h0);
        a1.if_req = 1'b0;
        step();
        chk("fetch_ready_pulse", {31'h0, a1.if_ready}, 32'h0);

        // Store, then load it back
        a1.d_req = 1'b1; a1.d_we = 1'b1; a1.d_addr = 32'h20; a1.d_wdata = 32'hDEAD_BEEF;
        step();
        chk("st_mem_en", {31'h0, a1.mem_en}, 32'h1);
        chk("st_mem_we", {31'h0, a1.mem_we}, 32'h1);
        chk("st_mem_addr", a1.mem_addr, 32'h20);
        chk("st_mem_wdata", a1.mem_wdata, 32'hDEAD_BEEF);
        step();
        chk("st_d_ready", {31'h0, a1.d_ready}, 32'h1);
        chk("st_d_rdata_kept", a1.d_rdata, 32'h0);
        chk("st_we_drop", {31'h0, a1.mem_we}, 32'h0);
        a1.d_req = 1'b0; a1.d_we = 1'b0;
        step();
        a1.d_req = 1'b1; a1.d_addr = 32'h20;
        step(); step();
        chk("ldback_ready", {31'h0, a1.d_ready}, 32'h1);
        chk("ldback_rdata", a1.d_rdata, 32'hDEAD_BEEF);
        a1.d_req = 1'b0;
        step();

        // Latency, LAT=3 load at 0x40
        noise_on = 1'b1;
        a3.d_req = 1'b1; a3.d_we = 1'b0; a3.d_addr = 32'h40;
        r = cyc;
        step();
        chk("lat_en_c1", {31'h0, a3.mem_en}, 32'h1);
        chk("lat_addr_c1", a3.mem_addr, 32'h40);
        step();
        chk("lat_en_c2", {31'h0, a3.mem_en}, 32'h0);
        chk("lat_addr_c2", a3.mem_addr, 32'h40);
        chk("lat_ready_c2", {31'h0, a3.d_ready}, 32'h0);
        step();
        chk("lat_addr_c3", a3.mem_addr, 32'h40);
        chk("lat_ready_c3", {31'h0, a3.d_ready}, 32'h0);
        step();
        chk("lat_ready", {31'h0, a3.d_ready}, 32'h1);
        chk("lat_rdata", a3.d_rdata, 32'h8C08_0000 ^ 32'(r + 3));
        a3.d_req = 1'b0;
        step();
        chk("lat_ready_pulse", {31'h0, a3.d_ready}, 32'h0);
        noise_on = 1'b0;

        // Reset in the middle of a LAT=3 fetch
        a3.if_req = 1'b1; a3.if_addr = 32'h8;
        step();
        chk("midrst_en_before", {31'h0, a3.mem_en}, 32'h1);
        reset = 1'b0;
        #1;
        chk("midrst_mem_en", {31'h0, a3.mem_en}, 32'h0);
        chk("midrst_if_ready", {31'h0, a3.if_ready}, 32'h0);
        chk("midrst_d_ready", {31'h0, a3.d_ready}, 32'h0);
        a3.if_req = 1'b0;
        step(); step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("postrst_mem_en", {31'h0, a3.mem_en}, 32'h0);
            chk("postrst_ready", {30'h0, a3.if_ready, a3.d_ready}, 32'h0);
            chk("postrst_if_rdata", a3.if_rdata, 32'h0);
        end

        // Contention and starvation guard, LAT=1
        m_s1 = 0;
        contend(10);
        contend(2);

        // Data alone first, fetch arrives one cycle later
        a1.d_req = 1'b1; a1.d_we = 1'b0; a1.d_addr = 32'hC;
        m_s1 = next_streak(1'b0, 1'b1, m_s1);
        step();
        a1.if_req = 1'b1; a1.if_addr = 32'h14;
        step();
        chk("sim_d_first", {30'h0, a1.if_ready, a1.d_ready}, 32'h1);
        chk("sim_d_rdata", a1.d_rdata, 32'h8C08_0003);
        a1.d_req = 1'b0;
        step();
        m_s1 = next_streak(1'b1, 1'b0, m_s1);
        step();
        chk("sim_if_wait", {30'h0, a1.if_ready, a1.d_ready}, 32'h0);
        step();
        chk("sim_if_second", {30'h0, a1.if_ready, a1.d_ready}, 32'h2);
        chk("sim_if_rdata", a1.if_rdata, 32'h8C08_0005);
        a1.if_req = 1'b0;
        step();
        contend(2);

        // A lone data grant must clear the streak built up above
        a1.d_req = 1'b1; a1.d_addr = 32'hC;
        m_s1 = next_streak(1'b0, 1'b1, m_s1);
        step(); step();
        chk("solo_d_ready", {30'h0, a1.if_ready, a1.d_ready}, 32'h1);
        a1.d_req = 1'b0;
        step();
        contend(5);

        // Randomized traffic on the LAT=3 port
        noise_on = 1'b1;
        m_s3 = 0; free_at = cyc; g_val = 1'b0; g_cyc = 0; g_d = 1'b0; g_we = 1'b0;
        g_addr = 32'h0; g_wdata = 32'h0;
        f_p = 1'b0; d_p = 1'b0; d_we_v = 1'b0;
        f_addr_v = 32'h0; d_addr_v = 32'h0; d_wdata_v = 32'h0;
        exp_ifr = 32'h0; exp_dr = 32'h0;
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h8C08_0000 + 32'(i);
        for (int it = 0; it < 900; it++) begin
            step();
            c = cyc;
            en_exp = g_val && (c == g_cyc + 1);
            chk("rnd_mem_en", {31'h0, a3.mem_en}, {31'h0, en_exp});
            if (g_val && c > g_cyc && c <= g_cyc + LAT3) chk("rnd_mem_addr", a3.mem_addr, g_addr);
            if (en_exp) begin
                chk("rnd_mem_we", {31'h0, a3.mem_we}, {31'h0, g_we});
                if (g_we) chk("rnd_mem_wdata", a3.mem_wdata, g_wdata);
            end
            rdy = g_val && (c == g_cyc + LAT3 + 1);
            chk("rnd_ready", {30'h0, a3.if_ready, a3.d_ready},
                rdy ? (g_d ? 32'h1 : 32'h2) : 32'h0);
            if (rdy) begin
                idx = int'(g_addr[5:2]);
                if (g_we)     ref_mem[idx] = g_wdata;
                else if (g_d) exp_dr  = ref_mem[idx] ^ 32'(g_cyc + LAT3);
                else          exp_ifr = ref_mem[idx] ^ 32'(g_cyc + LAT3);
                chk("rnd_if_rdata", a3.if_rdata, exp_ifr);
                chk("rnd_d_rdata", a3.d_rdata, exp_dr);
                if (g_d) begin d_p = 1'b0; a3.d_req = 1'b0; end
                else     begin f_p = 1'b0; a3.if_req = 1'b0; end
                g_val = 1'b0;
            end
            if (it < 860) begin
                if (!f_p && $urandom_range(3) == 0) begin
                    f_p = 1'b1; f_addr_v = $urandom();
                    a3.if_req = 1'b1; a3.if_addr = f_addr_v;
                end
                if (!d_p && $urandom_range(2) == 0) begin
                    d_p = 1'b1; d_we_v = 1'($urandom_range(1));
                    d_addr_v = $urandom(); d_wdata_v = $urandom();
                    a3.d_req = 1'b1; a3.d_we = d_we_v; a3.d_addr = d_addr_v; a3.d_wdata = d_wdata_v;
                end
            end
            if (!g_val && c >= free_at && (f_p || d_p)) begin
                g_d     = pick_d(f_p, d_p, m_s3);
                m_s3    = next_streak(f_p, d_p, m_s3);
                g_addr  = g_d ? d_addr_v : f_addr_v;
                g_we    = g_d && d_we_v;
                g_wdata = d_wdata_v;
                g_cyc   = c;
                free_at = c + LAT3 + 2;
                g_val   = 1'b1;
            end
        end
        chk("rnd_drained", {30'h0, f_p, d_p}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
